ifu_fetch: RTL and testbench
============================

IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port: stall  input  1  downstream cannot accept the presented instruction this cycle.
REQ-005 SHALL have port: redirect_valid  input  1  branch/jump taken, flush and refetch.
REQ-006 SHALL have port: redirect_pc  input  32  new fetch address, bits [1:0] ignored (treated as 0).
REQ-007 SHALL have port: imem_req  output  1  instruction memory request.
REQ-008 SHALL have port: imem_addr  output  32  request address, word aligned.
REQ-009 SHALL have port: imem_ack  input  1  one-cycle response strobe, only while imem_req=1.
REQ-010 SHALL have port: imem_rdata  input  32  instruction word, valid with imem_ack.
REQ-011 SHALL have port: pc  output  32  address of presented instruction, to IF/DE register.
REQ-012 SHALL have port: inst_o  output  32  presented instruction word, to IF/DE register.
REQ-013 SHALL have port: inst_valid  output  1  pc/inst_o hold a live instruction.

Function
REQ-014 SHALL implement states BOOT, FETCH, FULL, DROP; one output slot (pc, inst_o, inst_valid) plus one skid entry (pc, inst, valid); registers fetch_pc (next address) and req_addr (drives imem_addr).
REQ-015 SHALL treat the slot as consumed in any cycle with inst_valid=1 and stall=0.
REQ-016 BOOT SHALL drive imem_req=0 and go to FETCH next cycle with req_addr=fetch_pc=RESET_PC.
REQ-017 FETCH SHALL drive imem_req=1 and hold req_addr stable until imem_ack.
REQ-018 On ack in FETCH with slot empty or consumed that cycle, SHALL load slot with {req_addr, imem_rdata}, set inst_valid=1, advance fetch_pc and req_addr by 4, and stay in FETCH (back-to-back fetch, one instruction per ack).
REQ-019 On ack in FETCH with slot valid and stall=1, SHALL load the skid entry, advance by 4, and go to FULL.
REQ-020 FULL SHALL drive imem_req=0; on consume, SHALL move skid into slot, clear skid valid, go to FETCH.
REQ-021 Slot consumed with no ack and no skid SHALL clear inst_valid.
REQ-022 Address arithmetic SHALL be 32-bit modulo 2^32 (32'hFFFF_FFFC+4 wraps to 0).
REQ-023 redirect_valid SHALL take priority over every other event: clear inst_valid and skid valid, set fetch_pc=redirect_pc; any imem_rdata acked that cycle is discarded.
REQ-024 Redirect in FETCH without same-cycle ack SHALL go to DROP keeping req_addr; redirect with ack, or in FULL/BOOT, SHALL go to FETCH with req_addr=redirect_pc.
REQ-025 DROP SHALL keep imem_req=1 at old req_addr, discard data on ack, then go to FETCH with req_addr=fetch_pc; redirect in DROP updates fetch_pc only.
REQ-026 pc/inst_o SHALL hold their value while inst_valid=1 and stall=1.

Reset
REQ-027 rst_n=0 at a clock edge SHALL, regardless of state or outstanding request, set state=BOOT, pc=0, inst_o=0, inst_valid=0, skid cleared, fetch_pc=req_addr=RESET_PC, imem_req=0 next cycle; an ack arriving after reset SHALL be ignored.

Configuration
REQ-028 With IFU_FETCH_PERF_EN defined, SHALL add output flush_cnt (32-bit, reset 0, +1 per redirect_valid cycle, wraps); without it the port and counter SHALL not exist and behaviour is otherwise identical.

Verification
REQ-029 Reset release, ack every cycle, stall=0 -> imem_addr 0,4,8,...; pc/inst_o follow one cycle after each ack, inst_valid continuous.
REQ-030 Slot valid, stall=1, ack at addr 0x8 -> skid loaded, FULL, imem_req=0; stall drop -> pc=0x8 next cycle, FETCH resumes at 0xC.
REQ-031 Redirect to 0x100 while request to 0x10 pending -> DROP, 0x10 data discarded on ack, next request 0x100, inst_valid=0 until 0x100 returns.
REQ-032 Redirect and ack same cycle -> acked word never presented, next imem_addr=redirect_pc; redirect_pc=0x103 -> imem_addr=0x100.
REQ-033 rst_n low during DROP with ack in same cycle -> outputs zero, BOOT, then request at RESET_PC; with IFU_FETCH_PERF_EN, three redirects -> flush_cnt=3, reset -> 0.

Source files
------------

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - instruction fetch unit: one output slot, one skid entry, redirect flush
// Optional build macro IFU_FETCH_PERF_EN adds the flush_cnt redirect counter output.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] inst_o,
`ifdef IFU_FETCH_PERF_EN
  output logic [31:0] flush_cnt,
`endif
  output logic        inst_valid
);

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;
  localparam logic [1:0] ST_DROP  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        valid_q, valid_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_inst_q, skid_inst_d;
  logic        skid_valid_q, skid_valid_d;

  logic        ack;
  logic        consume;
  logic [31:0] redir_pc;
  logic [31:0] next_addr;

  assign imem_req   = (state_q == ST_FETCH) || (state_q == ST_DROP);
  assign imem_addr  = req_addr_q;
  assign pc         = pc_q;
  assign inst_o     = inst_q;
  assign inst_valid = valid_q;

  // An ack is only meaningful while a request is outstanding.
  assign ack       = imem_ack & imem_req;
  assign consume   = valid_q & ~stall;
  assign redir_pc  = redirect_pc & 32'hFFFF_FFFC;
  assign next_addr = req_addr_q + 32'd4;

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    req_addr_d   = req_addr_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    valid_d      = valid_q;
    skid_pc_d    = skid_pc_q;
    skid_inst_d  = skid_inst_q;
    skid_valid_d = skid_valid_q;

    if (redirect_valid) begin
      valid_d      = 1'b0;
      skid_valid_d = 1'b0;
      fetch_pc_d   = redir_pc;
      case (state_q)
        // Without an ack the old request is still in flight and must be drained.
        ST_FETCH: begin
          if (ack) req_addr_d = redir_pc;
          else     state_d    = ST_DROP;
        end
        ST_DROP: begin
          if (ack) begin
            state_d    = ST_FETCH;
            req_addr_d = redir_pc;
          end
        end
        default: begin
          state_d    = ST_FETCH;
          req_addr_d = redir_pc;
        end
      endcase
    end else begin
      case (state_q)
        ST_BOOT: state_d = ST_FETCH;
        ST_FETCH: begin
          if (ack) begin
            fetch_pc_d = next_addr;
            req_addr_d = next_addr;
            if (!valid_q || consume) begin
              pc_d    = req_addr_q;
              inst_d  = imem_rdata;
              valid_d = 1'b1;
            end else begin
              skid_pc_d    = req_addr_q;
              skid_inst_d  = imem_rdata;
              skid_valid_d = 1'b1;
              state_d      = ST_FULL;
            end
          end else if (consume) begin
            valid_d = 1'b0;
          end
        end
        ST_FULL: begin
          if (consume) begin
            pc_d         = skid_pc_q;
            inst_d       = skid_inst_q;
            valid_d      = skid_valid_q;
            skid_valid_d = 1'b0;
            state_d      = ST_FETCH;
          end
        end
        ST_DROP: begin
          if (consume) valid_d = 1'b0;
          if (ack) begin
            state_d    = ST_FETCH;
            req_addr_d = fetch_pc_q;
          end
        end
        default: state_d = ST_BOOT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_BOOT;
      fetch_pc_q   <= RESET_PC;
      req_addr_q   <= RESET_PC;
      pc_q         <= 32'd0;
      inst_q       <= 32'd0;
      valid_q      <= 1'b0;
      skid_pc_q    <= 32'd0;
      skid_inst_q  <= 32'd0;
      skid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      req_addr_q   <= req_addr_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      valid_q      <= valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_inst_q  <= skid_inst_d;
      skid_valid_q <= skid_valid_d;
    end
  end

`ifdef IFU_FETCH_PERF_EN
  logic [31:0] flush_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flush_cnt_q <= 32'd0;
    end else if (redirect_valid) begin
      flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - self-checking bench for ifu_fetch
// Program-order model plus directed literal expectations; honours IFU_FETCH_PERF_EN.
module tb_ifu_fetch;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] inst_o;
  logic        inst_valid;
`ifdef IFU_FETCH_PERF_EN
  logic [31:0] flush_cnt;
`endif

  int checks = 0;
  int failures = 0;
  logic force_ack = 1'b0;

  always #5 clk = ~clk;

  ifu_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .pc             (pc),
    .inst_o         (inst_o),
`ifdef IFU_FETCH_PERF_EN
    .flush_cnt      (flush_cnt),
`endif
    .inst_valid     (inst_valid)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs just after the edge; memory answers only an open request.
  task automatic cyc(input logic rn, input logic st, input logic rv,
                     input logic [31:0] rpc, input logic ak);
    @(posedge clk);
    #1;
    rst_n          = rn;
    stall          = st;
    redirect_valid = rv;
    redirect_pc    = rpc;
    imem_ack       = ak & (imem_req | force_ack);
    imem_rdata     = mem_word(imem_addr);
  endtask

  // Program-order model: consumed instructions walk addresses by 4, restarting at redirect targets.
  logic [31:0] exp_pc = RESET_PC;
  logic [31:0] exp_flush = 32'd0;
  logic        seen_rst = 1'b0;
  logic        was_rst = 1'b0;
  logic        was_redir = 1'b0;
  logic        was_hold = 1'b0;
  logic        was_wait = 1'b0;
  logic [31:0] held_pc = 32'd0;
  logic [31:0] held_inst = 32'd0;
  logic [31:0] wait_addr = 32'd0;

  always @(negedge clk) begin
    if (was_rst) begin
      check("m_rst_pc", pc, 32'd0);
      check("m_rst_inst", inst_o, 32'd0);
      check_b("m_rst_valid", inst_valid, 1'b0);
      check_b("m_rst_req", imem_req, 1'b0);
    end
`ifdef IFU_FETCH_PERF_EN
    if (seen_rst) check("m_flush_cnt", flush_cnt, exp_flush);
`endif
    if (!rst_n) begin
      seen_rst  = 1'b1;
      was_rst   = 1'b1;
      was_redir = 1'b0;
      was_hold  = 1'b0;
      was_wait  = 1'b0;
      exp_pc    = RESET_PC;
      exp_flush = 32'd0;
    end else if (seen_rst) begin
      if (was_redir) check_b("m_redir_clears", inst_valid, 1'b0);
      if (was_hold) begin
        check_b("m_hold_valid", inst_valid, 1'b1);
        check("m_hold_pc", pc, held_pc);
        check("m_hold_inst", inst_o, held_inst);
      end
      if (was_wait) begin
        check_b("m_wait_req", imem_req, 1'b1);
        check("m_wait_addr", imem_addr, wait_addr);
      end
      if (imem_req) check("m_addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
      if (inst_valid && !stall) begin
        check("m_pc", pc, exp_pc);
        check("m_inst", inst_o, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
      end
      if (redirect_valid) begin
        exp_pc    = redirect_pc & 32'hFFFF_FFFC;
        exp_flush = exp_flush + 32'd1;
      end
      was_rst   = 1'b0;
      was_redir = redirect_valid;
      was_hold  = inst_valid & stall & ~redirect_valid;
      held_pc   = pc;
      held_inst = inst_o;
      was_wait  = imem_req & ~imem_ack;
      wait_addr = imem_addr;
    end
  end

  initial begin
    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    imem_ack = 1'b0; imem_rdata = 32'd0;

    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    check_b("rst_req", imem_req, 1'b0);
    check("rst_pc", pc, 32'd0);
    check_b("rst_valid", inst_valid, 1'b0);
    check("rst_inst", inst_o, 32'd0);

    cyc(1, 0, 0, 0, 1);
    check_b("boot_req", imem_req, 1'b0);
    cyc(1, 0, 0, 0, 1);
    check("seq_addr0", imem_addr, 32'h0);
    check_b("seq_req0", imem_req, 1'b1);
    cyc(1, 0, 0, 0, 1);
    check("seq_addr4", imem_addr, 32'h4);
    check("seq_pc0", pc, 32'h0);
    check_b("seq_valid0", inst_valid, 1'b1);
    check("seq_inst0", inst_o, 32'hDEAD_BEEF);

    cyc(1, 1, 0, 0, 1);
    check("skid_addr8", imem_addr, 32'h8);
    check("skid_pc4", pc, 32'h4);
    cyc(1, 1, 0, 0, 1);
    check_b("full_req", imem_req, 1'b0);
    check("full_pc", pc, 32'h4);
    cyc(1, 0, 0, 0, 1);
    check_b("full_req2", imem_req, 1'b0);
    cyc(1, 0, 0, 0, 1);
    check("unskid_pc8", pc, 32'h8);
    check("resume_addrC", imem_addr, 32'hC);
    check_b("resume_req", imem_req, 1'b1);

    cyc(1, 0, 1, 32'h100, 0);
    check("pre_drop_pc", pc, 32'hC);
    check("pre_drop_addr", imem_addr, 32'h10);
    cyc(1, 0, 0, 0, 1);
    check("drop_addr", imem_addr, 32'h10);
    check_b("drop_req", imem_req, 1'b1);
    check_b("drop_valid", inst_valid, 1'b0);
    cyc(1, 0, 0, 0, 0);
    check("after_drop_addr", imem_addr, 32'h100);
    check_b("after_drop_valid", inst_valid, 1'b0);
    cyc(1, 0, 0, 0, 1);
    check("wait_addr100", imem_addr, 32'h100);
    check_b("wait_valid", inst_valid, 1'b0);
    cyc(1, 0, 1, 32'h203, 1);
    check("pc100", pc, 32'h100);
    check("inst100", inst_o, 32'hDEAD_BFEF);
    check("addr104", imem_addr, 32'h104);
    cyc(1, 0, 1, 32'hFFFF_FFF8, 1);
    check("redir_ack_addr", imem_addr, 32'h200);
    check_b("redir_ack_valid", inst_valid, 1'b0);
    cyc(1, 0, 0, 0, 1);
    check("wrap_addr_f8", imem_addr, 32'hFFFF_FFF8);
    cyc(1, 0, 0, 0, 1);
    check("wrap_pc_f8", pc, 32'hFFFF_FFF8);
    cyc(1, 0, 0, 0, 1);
    check("wrap_pc_fc", pc, 32'hFFFF_FFFC);
    check("wrap_addr0", imem_addr, 32'h0);
    cyc(1, 0, 0, 0, 0);
    check("wrap_pc0", pc, 32'h0);
    check_b("wrap_valid", inst_valid, 1'b1);

    for (int i = 0; i < 60; i++) begin
      cyc(1, (i % 5 == 1) || (i % 7 == 3), (i % 17 == 9),
          32'h400 + 32'(i) * 32'd8 + 32'd1, (i % 4 != 2));
    end

    cyc(1, 0, 1, 32'h40, 0);
    cyc(1, 0, 1, 32'h80, 0);
    cyc(0, 0, 0, 0, 1);
    check_b("drop_before_rst", imem_req, 1'b1);
    force_ack = 1'b1;
    cyc(0, 0, 0, 0, 1);
    check("rst2_pc", pc, 32'd0);
    check("rst2_inst", inst_o, 32'd0);
    check_b("rst2_valid", inst_valid, 1'b0);
    check_b("rst2_req", imem_req, 1'b0);
    cyc(1, 0, 0, 0, 1);
    check_b("boot2_valid", inst_valid, 1'b0);
    check_b("boot2_req", imem_req, 1'b0);
    force_ack = 1'b0;
    cyc(1, 0, 0, 0, 1);
    check("boot2_addr", imem_addr, RESET_PC);
    check_b("boot2_fetch_req", imem_req, 1'b1);
    check_b("boot2_fetch_valid", inst_valid, 1'b0);
    cyc(1, 0, 0, 0, 0);
    check("boot2_pc", pc, RESET_PC);
    check_b("boot2_pc_valid", inst_valid, 1'b1);

    cyc(1, 0, 1, 32'h300, 0);
    cyc(1, 0, 1, 32'h300, 0);
    cyc(1, 0, 1, 32'h300, 0);
    cyc(1, 0, 0, 0, 0);
`ifdef IFU_FETCH_PERF_EN
    check("flush_cnt3", flush_cnt, 32'd3);
`endif
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
`ifdef IFU_FETCH_PERF_EN
    check("flush_cnt_rst", flush_cnt, 32'd0);
`endif
    cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    @(posedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
